dma_multichannel: RTL

//  N-channel DMA engine; parametrised successor to the single-channel ROM->RAM DMA.

---
 rtl/dma_multichannel.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dma_multichannel.sv
// Multichannel DMA: copies ROM words (load/ready handshake) or a constant
// fill value into the destination write port. One channel runs at a time,
// chosen round-robin. The processor is stalled whenever the engine is not idle.
//
// state  | meaning
// IDLE   | bus returned to processor; arbitrate armed channels
// ISSUE  | one-cycle ROM read request at the current source address
// WAIT   | wait for ROM ready, latch returned word
// WRITE  | one-cycle destination write, advance addresses and count
// DONE   | release channel, pulse its done flag
module dma_multichannel #(
  parameter int NUM_CH = 2,
  parameter int SRC_AW = 23,
  parameter int DST_AW = 16,
  parameter int DW     = 16,
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              write,
  input  logic [1:0]        wr_mode,
  input  logic [CHW-1:0]    ch_sel,
  input  logic [DW-1:0]     ctrl_data,
  output logic [SRC_AW-1:0] src_addr,
  output logic              load_rom,
  input  logic [DW-1:0]     src_data,
  input  logic              ready,
  output logic [DST_AW-1:0] dst_addr,
  output logic              dst_write,
  output logic [DW-1:0]     dst_data,
  output logic              proc_en,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t state_q, state_d;

  logic [SRC_AW-1:0] src_q [NUM_CH];
  logic [DST_AW-1:0] dst_q [NUM_CH];
  logic [14:0]       len_q [NUM_CH];
  logic [NUM_CH-1:0] fill_q, busy_q, done_q;
  logic [CHW-1:0]    last_q, cur_q;

  logic [SRC_AW-1:0] wsrc_q;
  logic [DST_AW-1:0] wdst_q;
  logic [14:0]       wlen_q;
  logic              wfill_q;
  logic [DW-1:0]     data_q;

  logic              gnt_vld;
  logic [CHW-1:0]    gnt_ch;
  logic              wr_ok;

  // Register writes only while the processor owns the bus and the target channel is idle
  assign wr_ok = en & write & proc_en & ~busy_q[ch_sel];

  // Round-robin pick: first armed channel after the last one served
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!gnt_vld && busy_q[CHW'((int'(last_q) + i) % NUM_CH)]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CHW'((int'(last_q) + i) % NUM_CH);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_vld) state_d = fill_q[gnt_ch] ? S_WRITE : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (ready) state_d = S_WRITE;
      S_WRITE: begin
        if (wlen_q == 15'd1) state_d = S_DONE;
        else if (!wfill_q)   state_d = S_ISSUE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Channel programming, arm/release flags and zero-length done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        src_q[c] <= '0;
        dst_q[c] <= '0;
        len_q[c] <= '0;
      end
      fill_q <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      done_q <= '0;
      if (wr_ok) begin
        case (wr_mode)
          2'd0: src_q[ch_sel][15:0]        <= ctrl_data[15:0];
          2'd1: src_q[ch_sel][SRC_AW-1:16] <= ctrl_data[SRC_AW-17:0];
          2'd2: dst_q[ch_sel]              <= ctrl_data[DST_AW-1:0];
          default: begin
            fill_q[ch_sel] <= ctrl_data[15];
            len_q[ch_sel]  <= ctrl_data[14:0];
            if (ctrl_data[14:0] == 15'd0) done_q[ch_sel] <= 1'b1;
            else                          busy_q[ch_sel] <= 1'b1;
          end
        endcase
      end
      if (state_q == S_WRITE && state_d == S_DONE) busy_q[cur_q] <= 1'b0;
    end
  end

  // Transfer datapath: working copies loaded at grant, advanced per written word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= CHW'(NUM_CH - 1);
      cur_q   <= '0;
      wsrc_q  <= '0;
      wdst_q  <= '0;
      wlen_q  <= '0;
      wfill_q <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (gnt_vld) begin
          cur_q   <= gnt_ch;
          wsrc_q  <= src_q[gnt_ch];
          wdst_q  <= dst_q[gnt_ch];
          wlen_q  <= len_q[gnt_ch];
          wfill_q <= fill_q[gnt_ch];
          if (fill_q[gnt_ch]) data_q <= src_q[gnt_ch][DW-1:0];
        end
        S_WAIT: if (ready) data_q <= src_data;
        S_WRITE: begin
          wsrc_q <= wsrc_q + SRC_AW'(1);
          wdst_q <= wdst_q + DST_AW'(1);
          wlen_q <= wlen_q - 15'd1;
        end
        S_DONE: last_q <= cur_q;
        default: ;
      endcase
    end
  end

  assign proc_en   = (state_q == S_IDLE);
  assign load_rom  = (state_q == S_ISSUE);
  assign dst_write = (state_q == S_WRITE);
  assign src_addr  = wsrc_q;
  assign dst_addr  = wdst_q;
  assign dst_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q | ((state_q == S_DONE) ? (NUM_CH'(1) << cur_q) : '0);

endmodule
